// File: rtl/atm_pkg.sv
// ============================================================================
// Module   : atm_pkg
// Purpose  : Shared types and constants for the ATM session driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package atm_pkg;

  localparam int ATM_DATA_W = 16;

  localparam logic [7:0] DRV_ERR_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    OP_BAL    = 2'd0,
    OP_WDR    = 2'd1,
    OP_DEP    = 2'd2,
    OP_PINCHG = 2'd3
  } atm_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CARD     = 3'd1,
    PIN      = 3'd2,
    REQ      = 3'd3,
    WAIT_RSP = 3'd4,
    DONE     = 3'd5,
    RESULT   = 3'd6
  } drv_state_e;

endpackage

`default_nettype wire

// File: rtl/atm_session_driver_if.sv
// ============================================================================
// Module   : atm_session_driver_if
// Purpose  : Command, ATM-core and result signal bundle for the session driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface atm_session_driver_if;
  import atm_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ATM_DATA_W-1:0] cmd_pin;
  logic [1:0]            cmd_op;
  logic [ATM_DATA_W-1:0] cmd_amount;

  logic                  card_inserted;
  logic [ATM_DATA_W-1:0] pin_input;
  logic                  balance_req;
  logic                  withdrawal_req;
  logic                  deposit_req;
  logic                  pin_change_req;
  logic [ATM_DATA_W-1:0] amount;
  logic                  transaction_done;
  logic [7:0]            current_state;
  logic [ATM_DATA_W-1:0] balance;
  logic                  transaction_success;
  logic [7:0]            error_code;

  logic                  result_valid;
  logic                  result_ready;
  logic                  result_ok;
  logic [7:0]            result_err;
  logic [ATM_DATA_W-1:0] result_balance;

  // master = the session driver itself
  modport master (
    input  cmd_valid, cmd_pin, cmd_op, cmd_amount,
    input  current_state, balance, transaction_success, error_code,
    input  result_ready,
    output cmd_ready, card_inserted, pin_input,
    output balance_req, withdrawal_req, deposit_req, pin_change_req,
    output amount, transaction_done,
    output result_valid, result_ok, result_err, result_balance
  );

  modport slave (
    output cmd_valid, cmd_pin, cmd_op, cmd_amount,
    output current_state, balance, transaction_success, error_code,
    output result_ready,
    input  cmd_ready, card_inserted, pin_input,
    input  balance_req, withdrawal_req, deposit_req, pin_change_req,
    input  amount, transaction_done,
    input  result_valid, result_ok, result_err, result_balance
  );

endinterface

`default_nettype wire

// File: rtl/atm_drv_timer.sv
// ============================================================================
// Module   : atm_drv_timer
// Purpose  : Loadable down-counter that saturates at zero, with a zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module atm_drv_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/atm_session_driver.sv
// ============================================================================
// Module   : atm_session_driver
// Purpose  : Sequences one card/PIN/request/done session into the ATM core and
//            returns the response as a result record. Optional session and
//            error counters are built when ATM_DRV_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module atm_session_driver
  import atm_pkg::*;
#(
  parameter int PIN_WAIT_CYC = 4,
  parameter int TIMEOUT_CYC  = 64,
  parameter int TMR_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_session_driver_if.master bus
`ifdef ATM_DRV_STATS_EN
  ,
  output logic [15:0]          sess_count,
  output logic [15:0]          err_count
`endif
);

  // Timer is loaded with N-1 so that the owning state lasts exactly N cycles
  localparam logic [TMR_W-1:0] PIN_LOAD = TMR_W'((PIN_WAIT_CYC > 0) ? PIN_WAIT_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  drv_state_e            state_q, state_d;
  atm_op_e               op_q, op_d;
  logic [ATM_DATA_W-1:0] pin_q, pin_d;
  logic [ATM_DATA_W-1:0] amt_q, amt_d;
  logic                  ok_q, ok_d;
  logic [7:0]            err_q, err_d;
  logic [ATM_DATA_W-1:0] bal_q, bal_d;

  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_val;
  logic                  tmr_dec;
  logic                  tmr_zero;
  logic                  core_err;
  logic                  unused_state;

  assign core_err     = (bus.error_code != 8'h00);
  assign unused_state = ^bus.current_state;

  atm_drv_timer #(
    .TMR_W    (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pin_d    = pin_q;
    amt_d    = amt_q;
    ok_d     = ok_q;
    err_d    = err_q;
    bal_d    = bal_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = atm_op_e'(bus.cmd_op);
          pin_d   = bus.cmd_pin;
          amt_d   = bus.cmd_amount;
          ok_d    = 1'b0;
          err_d   = 8'h00;
          bal_d   = '0;
          state_d = CARD;
        end
      end
      CARD: begin
        tmr_load = 1'b1;
        tmr_val  = PIN_LOAD;
        state_d  = PIN;
      end
      PIN: begin
        tmr_dec = 1'b1;
        // Authentication failure closes the session without a request
        if (core_err) begin
          ok_d    = 1'b0;
          err_d   = bus.error_code;
          bal_d   = bus.balance;
          state_d = DONE;
        end else if (tmr_zero) begin
          state_d = REQ;
        end
      end
      REQ: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD;
        state_d  = WAIT_RSP;
      end
      WAIT_RSP: begin
        tmr_dec = 1'b1;
        if (core_err) begin
          ok_d    = 1'b0;
          err_d   = bus.error_code;
          bal_d   = bus.balance;
          state_d = DONE;
        end else if (bus.transaction_success) begin
          ok_d    = 1'b1;
          err_d   = 8'h00;
          bal_d   = bus.balance;
          state_d = DONE;
        end else if (tmr_zero) begin
          ok_d    = 1'b0;
          err_d   = DRV_ERR_TIMEOUT;
          state_d = DONE;
        end
      end
      DONE: begin
        pin_d   = '0;
        amt_d   = '0;
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_BAL;
      pin_q   <= '0;
      amt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 8'h00;
      bal_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pin_q   <= pin_d;
      amt_q   <= amt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      bal_q   <= bal_d;
    end
  end

  assign bus.cmd_ready        = (state_q == IDLE) && !rst;
  assign bus.card_inserted    = (state_q == CARD);
  assign bus.balance_req      = (state_q == REQ) && (op_q == OP_BAL);
  assign bus.withdrawal_req   = (state_q == REQ) && (op_q == OP_WDR);
  assign bus.deposit_req      = (state_q == REQ) && (op_q == OP_DEP);
  assign bus.pin_change_req   = (state_q == REQ) && (op_q == OP_PINCHG);
  assign bus.pin_input        = pin_q;
  assign bus.amount           = amt_q;
  assign bus.transaction_done = (state_q == DONE);
  assign bus.result_valid     = (state_q == RESULT);
  assign bus.result_ok        = ok_q;
  assign bus.result_err       = err_q;
  assign bus.result_balance   = bal_q;

`ifdef ATM_DRV_STATS_EN
  logic        res_hs;
  logic [15:0] sess_q, sess_d;
  logic [15:0] errc_q, errc_d;

  assign res_hs = (state_q == RESULT) && bus.result_ready;

  always_comb begin
    sess_d = sess_q;
    errc_d = errc_q;
    if (res_hs) begin
      if (sess_q != 16'hFFFF) begin
        sess_d = sess_q + 16'd1;
      end
      if (!ok_q && (errc_q != 16'hFFFF)) begin
        errc_d = errc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sess_q <= '0;
      errc_q <= '0;
    end else begin
      sess_q <= sess_d;
      errc_q <= errc_d;
    end
  end

  assign sess_count = sess_q;
  assign err_count  = errc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_atm_session_driver.sv
// ============================================================================
// Module   : tb_atm_session_driver
// Purpose  : Directed self-checking bench for atm_session_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_atm_session_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  int   req_cnt;
  int   card_cnt;

  atm_session_driver_if bus ();

`ifdef ATM_DRV_STATS_EN
  logic [15:0] sess_count;
  logic [15:0] err_count;
`endif

  atm_session_driver #(
    .PIN_WAIT_CYC (4),
    .TIMEOUT_CYC  (64),
    .TMR_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master)
`ifdef ATM_DRV_STATS_EN
    ,
    .sess_count (sess_count),
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.transaction_done) done_cnt++;
    if (bus.balance_req || bus.withdrawal_req || bus.deposit_req || bus.pin_change_req) req_cnt++;
    if (bus.card_inserted) card_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] pin, input logic [1:0] op, input logic [15:0] amt);
    bus.cmd_pin    = pin;
    bus.cmd_op     = op;
    bus.cmd_amount = amt;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // Cycles since the accept edge; CARD is cycle 1
  task automatic run_to_req(output int cyc);
    cyc = 1;
    while (!(bus.balance_req || bus.withdrawal_req || bus.deposit_req || bus.pin_change_req)
           && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take_result();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.result_valid !== 1'b0 || bus.pin_input !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b pin=%h, required 0 0 0000",
               bus.cmd_ready, bus.result_valid, bus.pin_input);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_balance();
    int cyc;
    int d0, r0, c0;
    d0 = done_cnt; r0 = req_cnt; c0 = card_cnt;
    send_cmd(16'h1234, 2'd0, 16'h0000);
    checks++;
    if (bus.card_inserted !== 1'b1 || bus.pin_input !== 16'h1234 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bal_card: card=%b pin=%h ready=%b, required 1 1234 0",
               bus.card_inserted, bus.pin_input, bus.cmd_ready);
    end
    run_to_req(cyc);
    checks++;
    if (cyc !== 6 || bus.balance_req !== 1'b1 || bus.withdrawal_req !== 1'b0) begin
      errors++;
      $display("FAIL bal_req_latency: cyc=%0d bal_req=%b wdr=%b, required 6 1 0",
               cyc, bus.balance_req, bus.withdrawal_req);
    end
    tick();
    bus.transaction_success = 1'b1;
    bus.balance             = 16'h03E8;
    tick();
    bus.transaction_success = 1'b0;
    bus.balance             = 16'h0000;
    checks++;
    if (bus.transaction_done !== 1'b1 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL bal_done: done=%b valid=%b, required 1 0", bus.transaction_done, bus.result_valid);
    end
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b1 || bus.result_err !== 8'h00
        || bus.result_balance !== 16'h03E8 || bus.pin_input !== 16'h0) begin
      errors++;
      $display("FAIL bal_result: valid=%b ok=%b err=%h bal=%h pin=%h, required 1 1 00 03e8 0000",
               bus.result_valid, bus.result_ok, bus.result_err, bus.result_balance, bus.pin_input);
    end
    take_result();
    checks++;
    if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bal_handshake: valid=%b ready=%b, required 0 1", bus.result_valid, bus.cmd_ready);
    end
    checks++;
    if (done_cnt - d0 !== 1 || req_cnt - r0 !== 1 || card_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL bal_pulses: done=%0d req=%0d card=%0d, required 1 1 1",
               done_cnt - d0, req_cnt - r0, card_cnt - c0);
    end
  endtask

  task automatic test_withdraw_error_wins();
    int cyc;
    int d0;
    d0 = done_cnt;
    send_cmd(16'h4321, 2'd1, 16'h0064);
    run_to_req(cyc);
    checks++;
    if (cyc !== 6 || bus.withdrawal_req !== 1'b1 || bus.amount !== 16'h0064) begin
      errors++;
      $display("FAIL wdr_req: cyc=%0d wdr=%b amount=%h, required 6 1 0064",
               cyc, bus.withdrawal_req, bus.amount);
    end
    tick();
    bus.transaction_success = 1'b1;
    bus.error_code          = 8'h02;
    bus.balance             = 16'h1111;
    tick();
    bus.transaction_success = 1'b0;
    bus.error_code          = 8'h00;
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b0 || bus.result_err !== 8'h02
        || bus.result_balance !== 16'h1111 || bus.amount !== 16'h0) begin
      errors++;
      $display("FAIL wdr_result: valid=%b ok=%b err=%h bal=%h amount=%h, required 1 0 02 1111 0000",
               bus.result_valid, bus.result_ok, bus.result_err, bus.result_balance, bus.amount);
    end
    take_result();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL wdr_done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_bad_pin();
    int d0, r0;
    d0 = done_cnt; r0 = req_cnt;
    send_cmd(16'h9999, 2'd0, 16'h0000);
    tick();
    bus.error_code = 8'h01;
    tick();
    bus.error_code = 8'h00;
    checks++;
    if (bus.transaction_done !== 1'b1) begin
      errors++;
      $display("FAIL badpin_done: got %b, required 1", bus.transaction_done);
    end
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b0 || bus.result_err !== 8'h01) begin
      errors++;
      $display("FAIL badpin_result: valid=%b ok=%b err=%h, required 1 0 01",
               bus.result_valid, bus.result_ok, bus.result_err);
    end
    take_result();
    checks++;
    if (req_cnt - r0 !== 0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL badpin_pulses: req=%0d done=%0d, required 0 1", req_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int n;
    send_cmd(16'h5555, 2'd2, 16'h0200);
    run_to_req(cyc);
    checks++;
    if (cyc !== 6 || bus.deposit_req !== 1'b1) begin
      errors++;
      $display("FAIL tmo_req: cyc=%0d dep=%b, required 6 1", cyc, bus.deposit_req);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.transaction_done && n < 200);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL tmo_latency: done after %0d cycles, required 65", n);
    end
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b0 || bus.result_err !== 8'hFF) begin
      errors++;
      $display("FAIL tmo_result: valid=%b ok=%b err=%h, required 1 0 ff",
               bus.result_valid, bus.result_ok, bus.result_err);
    end
    take_result();
`ifdef ATM_DRV_STATS_EN
    checks++;
    if (sess_count !== 16'd4 || err_count !== 16'd3) begin
      errors++;
      $display("FAIL stats: sess=%0d err=%0d, required 4 3", sess_count, err_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    int cyc;
    logic stable;
    send_cmd(16'h2468, 2'd3, 16'h5678);
    run_to_req(cyc);
    checks++;
    if (bus.pin_change_req !== 1'b1 || bus.amount !== 16'h5678) begin
      errors++;
      $display("FAIL pinchg_req: req=%b amount=%h, required 1 5678", bus.pin_change_req, bus.amount);
    end
    tick();
    bus.transaction_success = 1'b1;
    bus.balance             = 16'h0BB8;
    tick();
    bus.transaction_success = 1'b0;
    bus.balance             = 16'h0000;
    tick();
    stable = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b1 || bus.result_err !== 8'h00
          || bus.result_balance !== 16'h0BB8 || bus.cmd_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (stable !== 1'b1 || bus.result_balance !== 16'h0BB8) begin
      errors++;
      $display("FAIL backpressure_stable: stable=%b bal=%h, required 1 0bb8", stable, bus.result_balance);
    end
    take_result();
    tick();
    checks++;
    if (bus.card_inserted !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_no_queue: card=%b ready=%b, required 0 1",
               bus.card_inserted, bus.cmd_ready);
    end
`ifdef ATM_DRV_STATS_EN
    checks++;
    if (sess_count !== 16'd5 || err_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_bp: sess=%0d err=%0d, required 5 3", sess_count, err_count);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    int d0;
    send_cmd(16'h1111, 2'd1, 16'h0010);
    run_to_req(cyc);
    tick();
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pin_input !== 16'h0 || bus.amount !== 16'h0 || bus.cmd_ready !== 1'b0
        || bus.transaction_done !== 1'b0 || bus.result_valid !== 1'b0
        || bus.withdrawal_req !== 1'b0 || bus.result_err !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: pin=%h amt=%h ready=%b done=%b valid=%b wdr=%b err=%h, required all 0",
               bus.pin_input, bus.amount, bus.cmd_ready, bus.transaction_done,
               bus.result_valid, bus.withdrawal_req, bus.result_err);
    end
`ifdef ATM_DRV_STATS_EN
    checks++;
    if (sess_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: sess=%0d err=%0d, required 0 0", sess_count, err_count);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (done_cnt !== d0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_done: done_delta=%0d ready=%b, required 0 1", done_cnt - d0, bus.cmd_ready);
    end
  endtask

  task automatic test_after_reset();
    int cyc;
    send_cmd(16'h7777, 2'd0, 16'h0000);
    run_to_req(cyc);
    checks++;
    if (cyc !== 6 || bus.balance_req !== 1'b1 || bus.pin_input !== 16'h7777) begin
      errors++;
      $display("FAIL post_reset_req: cyc=%0d bal_req=%b pin=%h, required 6 1 7777",
               cyc, bus.balance_req, bus.pin_input);
    end
    tick();
    tick();
    bus.transaction_success = 1'b1;
    bus.balance             = 16'h00AA;
    tick();
    bus.transaction_success = 1'b0;
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_ok !== 1'b1 || bus.result_balance !== 16'h00AA) begin
      errors++;
      $display("FAIL post_reset_result: valid=%b ok=%b bal=%h, required 1 1 00aa",
               bus.result_valid, bus.result_ok, bus.result_balance);
    end
    take_result();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    req_cnt  = 0;
    card_cnt = 0;
    rst                     = 1'b1;
    bus.cmd_valid           = 1'b0;
    bus.cmd_pin             = 16'h0;
    bus.cmd_op              = 2'd0;
    bus.cmd_amount          = 16'h0;
    bus.current_state       = 8'h00;
    bus.balance             = 16'h0;
    bus.transaction_success = 1'b0;
    bus.error_code          = 8'h00;
    bus.result_ready        = 1'b0;

    test_reset();
    test_balance();
    test_withdraw_error_wins();
    test_bad_pin();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_after_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
